// File: rtl/fabricport_serializer.sv
// Splits RATIO-flit RTL words into NoC flits, with a word FIFO and per-VC credit flow control.
// Optional statistics counters are built when FABRICPORT_STATS_EN is defined.
module fabricport_serializer #(
  parameter int WIDTH_NOC    = 128,
  parameter int RATIO        = 4,
  parameter int NUM_VC       = 2,
  parameter int DEPTH        = 4,
  parameter int DEPTH_PER_VC = 8,
  localparam int WIDTH_RTL   = WIDTH_NOC * RATIO,
  localparam int VC_W        = $clog2(NUM_VC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_RTL-1:0] i_packet_in,
  input  logic                 i_valid_in,
  output logic                 i_ready_out,
  output logic [WIDTH_NOC-1:0] o_flit_out,
  output logic                 o_flit_valid_out,
  input  logic [NUM_VC-1:0]    i_credit_in,
  output logic                 o_busy_out
`ifdef FABRICPORT_STATS_EN
  ,
  output logic [31:0]          o_flit_count,
  output logic [31:0]          o_pkt_count
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int SLOT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [WIDTH_RTL-1:0] mem_q [DEPTH];
  logic [PTR_W:0]       wrPtr_q, rdPtr_q;
  logic                 fifoEmpty, fifoFull, push, pop;
  logic [WIDTH_RTL-1:0] headWord;

  state_t               state_q, state_d;
  logic [WIDTH_RTL-1:0] shift_q, shift_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [WIDTH_NOC-1:0] flit_q, flit_d;
  logic                 flitValid_q, flitValid_d;
  logic [7:0]           credit_q [NUM_VC];
  logic [7:0]           credit_d [NUM_VC];

  logic [WIDTH_NOC-1:0] curFlit;
  logic                 curValid;
  logic [VC_W-1:0]      curVc;
  logic                 creditOk, emit, advance;

  // The wrap bit tells a full FIFO from an empty one when the index bits match.
  assign fifoEmpty   = (wrPtr_q == rdPtr_q);
  assign fifoFull    = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                       (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign i_ready_out = !fifoFull;
  assign push        = i_valid_in && i_ready_out;
  assign headWord    = mem_q[rdPtr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q[PTR_W-1:0]] <= i_packet_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // The current slot always sits in the top flit of the shift register.
  assign curFlit  = shift_q[WIDTH_RTL-1 -: WIDTH_NOC];
  assign curValid = curFlit[WIDTH_NOC-1];
  assign curVc    = curFlit[WIDTH_NOC-4 -: VC_W];

  // A VC number with no counter behind it never has credit and stalls.
  always_comb begin
    creditOk = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (curVc == VC_W'(v) && credit_q[v] != 8'd0) creditOk = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    slot_d      = slot_q;
    flit_d      = flit_q;
    flitValid_d = 1'b0;
    pop         = 1'b0;
    emit        = 1'b0;
    advance     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          shift_d = headWord;
          slot_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!curValid) begin
          advance = 1'b1;
        end else if (creditOk) begin
          emit        = 1'b1;
          advance     = 1'b1;
          flitValid_d = 1'b1;
          flit_d      = curFlit;
        end
        if (advance) begin
          if (slot_q == SLOT_W'(RATIO - 1)) begin
            slot_d = '0;
            if (!fifoEmpty) begin
              pop     = 1'b1;
              shift_d = headWord;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d = shift_q << WIDTH_NOC;
            slot_d  = slot_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      slot_q      <= '0;
      flit_q      <= '0;
      flitValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      slot_q      <= slot_d;
      flit_q      <= flit_d;
      flitValid_q <= flitValid_d;
    end
  end

  // A return and an emit on the same VC cancel; returns saturate at the initial credit.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      credit_d[v] = credit_q[v];
      if (i_credit_in[v] && !(emit && curVc == VC_W'(v))) begin
        if (credit_q[v] < 8'(DEPTH_PER_VC)) credit_d[v] = credit_q[v] + 8'd1;
      end else if (!i_credit_in[v] && emit && curVc == VC_W'(v)) begin
        credit_d[v] = credit_q[v] - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (!rst) credit_q[v] <= 8'(DEPTH_PER_VC);
      else      credit_q[v] <= credit_d[v];
    end
  end

  assign o_flit_out       = flit_q;
  assign o_flit_valid_out = flitValid_q;
  assign o_busy_out       = !fifoEmpty || (state_q != IDLE);

`ifdef FABRICPORT_STATS_EN
  logic [31:0] flitCount_q, pktCount_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      flitCount_q <= '0;
      pktCount_q  <= '0;
    end else if (emit) begin
      flitCount_q <= flitCount_q + 32'd1;
      if (curFlit[WIDTH_NOC-3]) pktCount_q <= pktCount_q + 32'd1;
    end
  end

  assign o_flit_count = flitCount_q;
  assign o_pkt_count  = pktCount_q;
`else
  // Statistics disabled: no counter state is built.
`endif

endmodule

// File: tb/tb_fabricport_serializer.sv
// Directed bench for fabricport_serializer: one default instance and one with two credits per VC.
// Statistics checks are compiled in when FABRICPORT_STATS_EN is defined.
module tb_fabricport_serializer;

  logic         clk;
  logic         rst;

  logic [511:0] packetIn;
  logic         validIn, readyOut, flitValidOut, busyOut;
  logic [127:0] flitOut;
  logic [1:0]   creditIn;

  logic [511:0] bPacketIn;
  logic         bValidIn, bReadyOut, bFlitValidOut, bBusyOut;
  logic [127:0] bFlitOut;
  logic [1:0]   bCreditIn;

`ifdef FABRICPORT_STATS_EN
  logic [31:0]  flitCount, pktCount, bFlitCount, bPktCount;
`endif

  int           passCount = 0;
  int           checkCount = 0;
  logic [31:0]  validBits, bValidBits;
  logic [127:0] flitLog [32];
  logic [127:0] bFlitLog [32];

  logic [127:0] a0, a1, a2, a3, b0, b1, b2, b3, c0, c1, c2, c3;

  fabricport_serializer dut (
    .clk              (clk),
    .rst              (rst),
    .i_packet_in      (packetIn),
    .i_valid_in       (validIn),
    .i_ready_out      (readyOut),
    .o_flit_out       (flitOut),
    .o_flit_valid_out (flitValidOut),
    .i_credit_in      (creditIn),
    .o_busy_out       (busyOut)
`ifdef FABRICPORT_STATS_EN
    ,
    .o_flit_count     (flitCount),
    .o_pkt_count      (pktCount)
`endif
  );

  fabricport_serializer #(.DEPTH_PER_VC(2)) dutB (
    .clk              (clk),
    .rst              (rst),
    .i_packet_in      (bPacketIn),
    .i_valid_in       (bValidIn),
    .i_ready_out      (bReadyOut),
    .o_flit_out       (bFlitOut),
    .o_flit_valid_out (bFlitValidOut),
    .i_credit_in      (bCreditIn),
    .o_busy_out       (bBusyOut)
`ifdef FABRICPORT_STATS_EN
    ,
    .o_flit_count     (bFlitCount),
    .o_pkt_count      (bPktCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] makeFlit(input logic v, input logic h, input logic t,
                                            input logic vc, input logic [15:0] payload);
    logic [127:0] f;
    f = '0;
    f[127] = v;
    f[126] = h;
    f[125] = t;
    f[124] = vc;
    f[15:0] = payload;
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Logs both instances' outputs at this negedge and the following n-1 negedges.
  task automatic applyStimulus(input int n);
    validBits  = '0;
    bValidBits = '0;
    for (int i = 0; i < n; i++) begin
      validBits[i]  = flitValidOut;
      bValidBits[i] = bFlitValidOut;
      flitLog[i]    = flitOut;
      bFlitLog[i]   = bFlitOut;
      if (i < n - 1) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    packetIn = '0; validIn = 1'b0; creditIn = '0;
    bPacketIn = '0; bValidIn = 1'b0; bCreditIn = '0;
    repeat (3) @(negedge clk);

    checkOutput("reset ready", 128'(readyOut), 128'd1);
    checkOutput("reset flit valid", 128'(flitValidOut), 128'd0);
    checkOutput("reset busy", 128'(busyOut), 128'd0);
    checkOutput("reset credit0", 128'(dut.credit_q[0]), 128'd8);
    checkOutput("reset credit1", 128'(dut.credit_q[1]), 128'd8);
    rst = 1'b1;

    // One full packet on VC1: four back-to-back flits, first two cycles after accept.
    a0 = makeFlit(1, 1, 0, 1, 16'h1a00);
    a1 = makeFlit(1, 0, 0, 1, 16'h1a01);
    a2 = makeFlit(1, 0, 0, 1, 16'h1a02);
    a3 = makeFlit(1, 0, 1, 1, 16'h1a03);
    @(negedge clk);
    packetIn = {a0, a1, a2, a3};
    validIn = 1'b1;
    @(negedge clk);
    validIn = 1'b0;
    applyStimulus(8);
    checkOutput("full word valid pattern", 128'(validBits), 128'h3c);
    checkOutput("full word flit0", flitLog[2], a0);
    checkOutput("full word flit1", flitLog[3], a1);
    checkOutput("full word flit2", flitLog[4], a2);
    checkOutput("full word flit3", flitLog[5], a3);
    checkOutput("full word credit1", 128'(dut.credit_q[1]), 128'd4);
    checkOutput("full word credit0", 128'(dut.credit_q[0]), 128'd8);
    checkOutput("full word busy", 128'(busyOut), 128'd0);

    // Six returns against four spent credits must stop at the initial value.
    @(negedge clk);
    creditIn = 2'b10;
    repeat (6) @(negedge clk);
    creditIn = 2'b00;
    @(negedge clk);
    checkOutput("credit saturation", 128'(dut.credit_q[1]), 128'd8);

    // Slots 1 and 3 invalid: each skip costs one idle cycle.
    b0 = makeFlit(1, 1, 0, 0, 16'h2b00);
    b2 = makeFlit(1, 0, 1, 0, 16'h2b02);
    packetIn = {b0, 128'd0, b2, 128'd0};
    validIn = 1'b1;
    @(negedge clk);
    validIn = 1'b0;
    applyStimulus(8);
    checkOutput("skip valid pattern", 128'(validBits), 128'h14);
    checkOutput("skip flit slot0", flitLog[2], b0);
    checkOutput("skip flit slot2", flitLog[4], b2);
    checkOutput("skip credit0", 128'(dut.credit_q[0]), 128'd6);
    @(negedge clk);
    creditIn = 2'b11;
    repeat (2) @(negedge clk);
    creditIn = 2'b00;
    @(negedge clk);
    checkOutput("restore credit0", 128'(dut.credit_q[0]), 128'd8);
    checkOutput("restore credit1", 128'(dut.credit_q[1]), 128'd8);

    // Two credits on VC0: two flits, then one flit per returned credit.
    c0 = makeFlit(1, 1, 0, 0, 16'h3c00);
    c1 = makeFlit(1, 0, 0, 0, 16'h3c01);
    c2 = makeFlit(1, 0, 0, 0, 16'h3c02);
    c3 = makeFlit(1, 0, 1, 0, 16'h3c03);
    bPacketIn = {c0, c1, c2, c3};
    bValidIn = 1'b1;
    @(negedge clk);
    bValidIn = 1'b0;
    applyStimulus(8);
    checkOutput("credit stall pattern", 128'(bValidBits), 128'h0c);
    checkOutput("credit stall flit0", bFlitLog[2], c0);
    checkOutput("credit stall flit1", bFlitLog[3], c1);
    checkOutput("credit stall busy", 128'(bBusyOut), 128'd1);
    @(negedge clk);
    bCreditIn = 2'b01;
    @(negedge clk);
    bCreditIn = 2'b00;
    applyStimulus(6);
    checkOutput("one credit one flit pattern", 128'(bValidBits), 128'h02);
    checkOutput("one credit flit2", bFlitLog[1], c2);
    checkOutput("one credit still busy", 128'(bBusyOut), 128'd1);
    @(negedge clk);
    bCreditIn = 2'b01;
    @(negedge clk);
    bCreditIn = 2'b00;
    applyStimulus(4);
    checkOutput("last credit pattern", 128'(bValidBits), 128'h02);
    checkOutput("last credit flit3", bFlitLog[1], c3);
    checkOutput("last credit idle", 128'(bBusyOut), 128'd0);
    checkOutput("credits exhausted", 128'(dutB.credit_q[0]), 128'd0);

    // Stalled output: one word held in the shifter, four more fill the FIFO.
    @(negedge clk);
    bPacketIn = {makeFlit(1, 1, 1, 0, 16'h4000), 384'd0};
    bValidIn = 1'b1;
    @(negedge clk);
    bPacketIn = {c0, c1, c2, c3};
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("fifo three words ready", 128'(bReadyOut), 128'd1);
    @(negedge clk);
    checkOutput("fifo full after 4th accept", 128'(bReadyOut), 128'd0);
    bPacketIn = {a0, a1, a2, a3};
    @(negedge clk);
    checkOutput("fifo full holds 5th", 128'(bReadyOut), 128'd0);
    bCreditIn = 2'b01;
    @(negedge clk);
    bCreditIn = 2'b00;
    @(negedge clk);
    checkOutput("held word emits", 128'(bFlitValidOut), 128'd1);
    checkOutput("held word flit", bFlitOut, makeFlit(1, 1, 1, 0, 16'h4000));
    checkOutput("full while skipping", 128'(bReadyOut), 128'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("full before pop", 128'(bReadyOut), 128'd0);
    @(negedge clk);
    checkOutput("ready after first pop", 128'(bReadyOut), 128'd1);
    @(negedge clk);
    checkOutput("5th accepted refills", 128'(bReadyOut), 128'd0);
    bValidIn = 1'b0;

    // Reset after two of four flits: nothing more comes out and credits refill.
    @(negedge clk);
    packetIn = {c0, c1, c2, c3};
    validIn = 1'b1;
    @(negedge clk);
    validIn = 1'b0;
    applyStimulus(4);
    checkOutput("pre-reset two flits", 128'(validBits), 128'h0c);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid reset flit valid", 128'(flitValidOut), 128'd0);
    checkOutput("mid reset busy", 128'(busyOut), 128'd0);
    checkOutput("mid reset ready", 128'(readyOut), 128'd1);
    checkOutput("mid reset credit0", 128'(dut.credit_q[0]), 128'd8);
    checkOutput("mid reset credit1", 128'(dut.credit_q[1]), 128'd8);
    checkOutput("mid reset B busy", 128'(bBusyOut), 128'd0);
    checkOutput("mid reset B ready", 128'(bReadyOut), 128'd1);
    checkOutput("mid reset B credit0", 128'(dutB.credit_q[0]), 128'd2);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(6);
    checkOutput("no flits after reset", 128'(validBits), 128'h0);
    checkOutput("no B flits after reset", 128'(bValidBits), 128'h0);

    // Three words back to back: SEND reloads directly, twelve flits with no gaps.
    b1 = makeFlit(1, 0, 0, 1, 16'h2b01);
    b2 = makeFlit(1, 0, 0, 1, 16'h2b02);
    b0 = makeFlit(1, 1, 0, 1, 16'h2b00);
    b3 = makeFlit(1, 0, 1, 1, 16'h2b03);
    a0 = makeFlit(1, 1, 0, 0, 16'h1a00);
    a1 = makeFlit(1, 0, 0, 0, 16'h1a01);
    a2 = makeFlit(1, 0, 0, 0, 16'h1a02);
    a3 = makeFlit(1, 0, 1, 0, 16'h1a03);
    @(negedge clk);
    packetIn = {a0, a1, a2, a3};
    validIn = 1'b1;
    @(negedge clk);
    packetIn = {b0, b1, b2, b3};
    @(negedge clk);
    packetIn = {c0, c1, c2, c3};
    @(negedge clk);
    validIn = 1'b0;
    applyStimulus(14);
    checkOutput("burst valid pattern", 128'(validBits), 128'h0fff);
    checkOutput("burst a0", flitLog[0], a0);
    checkOutput("burst a3", flitLog[3], a3);
    checkOutput("burst b0", flitLog[4], b0);
    checkOutput("burst b3", flitLog[7], b3);
    checkOutput("burst c0", flitLog[8], c0);
    checkOutput("burst c3", flitLog[11], c3);
    checkOutput("burst credit0", 128'(dut.credit_q[0]), 128'd0);
    checkOutput("burst credit1", 128'(dut.credit_q[1]), 128'd4);
    checkOutput("burst busy", 128'(busyOut), 128'd0);
`ifdef FABRICPORT_STATS_EN
    checkOutput("stats flit count", 128'(flitCount), 128'd12);
    checkOutput("stats pkt count", 128'(pktCount), 128'd3);
    checkOutput("stats B flit count", 128'(bFlitCount), 128'd0);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
